// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/lap/clear controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RUN_LAP = 2'd2,
    PAUSE   = 2'd3
  } sw_state_t;

  localparam int SEC_W        = 6;
  localparam int MIN_W        = 6;
  localparam int TICK_DIV_DEF = 100_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while en is low, so a pause keeps the sub-second phase.
module tick_prescaler #(
  parameter int  TICK_DIV = 100_000_000,
  localparam int PW       = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/lap/pause/idle controller: turns button pulses into counter enable/clear
// and picks live or frozen lap time for the display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             lap_clr,
  input  logic [SEC_W-1:0] sec_in,
  input  logic [MIN_W-1:0] min_in,
  output logic             count_en,
  output logic             count_clr,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MIN_W-1:0] disp_min,
  output logic             running,
  output logic             lap_active
);

  sw_state_t        state_q, state_d;
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
  logic [MIN_W-1:0] lap_min_q, lap_min_d;
  logic             clr_q, clr_d;

  assign running    = (state_q == RUN) || (state_q == RUN_LAP);
  assign lap_active = (state_q == RUN_LAP);
  assign count_clr  = clr_q;
  assign disp_sec   = lap_active ? lap_sec_q : sec_in;
  assign disp_min   = lap_active ? lap_min_q : min_in;

  // start_stop always wins over a coincident lap_clr.
  always_comb begin
    state_d   = state_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    clr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop)   state_d = RUN;
        else if (lap_clr) clr_d   = 1'b1;
      end
      RUN: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap_clr) begin
          state_d   = RUN_LAP;
          lap_sec_d = sec_in;
          lap_min_d = min_in;
        end
      end
      RUN_LAP: begin
        if (start_stop)   state_d = PAUSE;
        else if (lap_clr) state_d = RUN;
      end
      PAUSE: begin
        if (start_stop) begin
          state_d = RUN;
        end else if (lap_clr) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lap_sec_q <= '0;
      lap_min_q <= '0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
      clr_q     <= clr_d;
    end
  end

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (running),
    .clr (clr_q),
    .tick(count_en)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV = 4: vector table, directed sequences,
// and random buttons against a cycle-level reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       lap_clr;
  logic [5:0] sec_in;
  logic [5:0] min_in;
  logic       count_en;
  logic       count_clr;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic       running;
  logic       lap_active;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .lap_clr   (lap_clr),
    .sec_in    (sec_in),
    .min_in    (min_in),
    .count_en  (count_en),
    .count_clr (count_clr),
    .disp_sec  (disp_sec),
    .disp_min  (disp_min),
    .running   (running),
    .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode names, elapsed phase within a second, lap snapshot.
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
  int m_mode, m_phase, m_lap_s, m_lap_m;
  bit m_clr;

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_lap_s = 0; m_lap_m = 0; m_clr = 0;
  endtask

  function automatic bit m_running();
    return (m_mode == M_RUN) || (m_mode == M_LAP);
  endfunction

  task automatic model_check();
    check("running",    running,    m_running());
    check("lap_active", lap_active, m_mode == M_LAP);
    check("count_en",   count_en,   m_running() && (m_phase == TD - 1));
    check("count_clr",  count_clr,  m_clr);
    check("disp_sec",   disp_sec,   (m_mode == M_LAP) ? m_lap_s : int'(sec_in));
    check("disp_min",   disp_min,   (m_mode == M_LAP) ? m_lap_m : int'(min_in));
  endtask

  task automatic model_step(input bit ss, input bit lc, input int s, input int m);
    bit next_clr;
    next_clr = (m_mode == M_IDLE || m_mode == M_PAUSE) && lc && !ss;
    if (m_clr)            m_phase = 0;
    else if (m_running()) m_phase = (m_phase + 1) % TD;
    if (ss) begin
      m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
    end else if (lc) begin
      case (m_mode)
        M_RUN:   begin m_mode = M_LAP; m_lap_s = s; m_lap_m = m; end
        M_LAP:   m_mode = M_RUN;
        M_PAUSE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
    m_clr = next_clr;
  endtask

  logic       obs_en, obs_run, obs_clr, obs_lap;
  logic [5:0] obs_sec, obs_min;

  // Called just after a rising edge; checks at the falling edge, steps the model.
  task automatic drive_cycle(input bit ss, input bit lc, input logic [5:0] s, input logic [5:0] m);
    start_stop = ss; lap_clr = lc; sec_in = s; min_in = m;
    @(negedge clk);
    model_check();
    obs_en = count_en; obs_run = running; obs_clr = count_clr;
    obs_lap = lap_active; obs_sec = disp_sec; obs_min = disp_min;
    @(posedge clk);
    model_step(ss, lc, int'(s), int'(m));
    #1;
    start_stop = 1'b0;
    lap_clr    = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs respond before any edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_running",    running,    0);
    check("rst_lap_active", lap_active, 0);
    check("rst_count_en",   count_en,   0);
    check("rst_count_clr",  count_clr,  0);
    check("rst_disp_sec",   disp_sec,   sec_in);
    check("rst_disp_min",   disp_min,   min_in);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  typedef struct {
    bit ss; bit lc; logic [5:0] sec; logic [5:0] min;
    logic [5:0] e_sec; logic [5:0] e_min; bit e_run; bit e_lap; bit e_clr;
  } vec_t;

  vec_t vt [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // start, lap at sec 7, release, simultaneous press, clear from pause
    vt[0]  = '{1, 0,  5, 3,  5, 3, 0, 0, 0};
    vt[1]  = '{0, 0,  6, 3,  6, 3, 1, 0, 0};
    vt[2]  = '{0, 1,  7, 3,  7, 3, 1, 0, 0};
    vt[3]  = '{0, 0,  8, 4,  7, 3, 1, 1, 0};
    vt[4]  = '{0, 0,  9, 4,  7, 3, 1, 1, 0};
    vt[5]  = '{0, 1,  9, 4,  7, 3, 1, 1, 0};
    vt[6]  = '{0, 0, 10, 4, 10, 4, 1, 0, 0};
    vt[7]  = '{1, 1, 11, 4, 11, 4, 1, 0, 0};
    vt[8]  = '{0, 0, 12, 4, 12, 4, 0, 0, 0};
    vt[9]  = '{0, 1, 12, 4, 12, 4, 0, 0, 0};
    vt[10] = '{0, 0,  0, 0,  0, 0, 0, 0, 1};
    vt[11] = '{0, 0,  0, 0,  0, 0, 0, 0, 0};

    rst = 1'b0; start_stop = 1'b0; lap_clr = 1'b0; sec_in = 6'd17; min_in = 6'd2;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    for (int c = 0; c < 20; c++) begin
      drive_cycle(0, 0, 6'd17, 6'd2);
      check("idle_en", obs_en, 0);
      check("idle_run", obs_run, 0);
      check("idle_clr", obs_clr, 0);
    end

    do_reset();
    for (int c = 0; c < 26; c++) begin
      drive_cycle(c == 10, 0, 6'd0, 6'd0);
      check("start_run", obs_run, c >= 11);
      check("start_en", obs_en, (c == 14 || c == 18 || c == 22));
    end

    // pause two cycles after start, resume much later: phase is kept
    do_reset();
    for (int c = 0; c < 42; c++) begin
      drive_cycle(c == 10 || c == 12 || c == 30, 0, 6'd0, 6'd0);
      check("pause_en", obs_en, (c == 32 || c == 36 || c == 40));
    end

    // pause on the terminal cycle: enable still fires, resume starts a full second
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive_cycle(c == 0 || c == 4 || c == 8, 0, 6'd0, 6'd0);
      check("wrap_en", obs_en, (c == 4 || c == 12));
    end

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_cycle(vt[i].ss, vt[i].lc, vt[i].sec, vt[i].min);
      check($sformatf("vec%0d_sec", i), obs_sec, vt[i].e_sec);
      check($sformatf("vec%0d_min", i), obs_min, vt[i].e_min);
      check($sformatf("vec%0d_run", i), obs_run, vt[i].e_run);
      check($sformatf("vec%0d_lap", i), obs_lap, vt[i].e_lap);
      check($sformatf("vec%0d_clr", i), obs_clr, vt[i].e_clr);
    end
    // prescaler cleared with the counters: restart yields a full first second
    for (int c = 0; c < 7; c++) begin
      drive_cycle(c == 0, 0, 6'd0, 6'd0);
      check("clr_restart_en", obs_en, c == 4);
    end

    // async reset while the lap freeze is active
    do_reset();
    for (int c = 0; c < 5; c++) drive_cycle(c == 0, c == 2, 6'(30 + c), 6'd9);
    check("pre_rst_lap", lap_active, 1);
    sec_in = 6'd44;
    #2;
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499, 0) == 0) begin
        do_reset();
      end else begin
        drive_cycle($urandom_range(7, 0) == 0, $urandom_range(5, 0) == 0,
                    6'($urandom_range(59, 0)), 6'($urandom_range(59, 0)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
